// File: rtl/nvc_video_pkg.sv
// Shared video-pipeline definitions: default line geometry, the pixel code type,
// and the line-buffer state and output-source encodings.
package nvc_video_pkg;

   localparam int             LB_DW       = 6;
   localparam int             LB_LINE_LEN = 288;
   localparam int             LB_XW       = 9;
   localparam logic [LB_DW-1:0] LB_TRANSP = 6'd0;

   typedef logic [LB_DW-1:0] pix_t;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } lb_state_t;

   // Which source currently drives dout; TRANSP covers reset and saturated reads.
   typedef enum logic [1:0] {
      SRC_TRANSP = 2'd0,
      SRC_BANK0  = 2'd1,
      SRC_BANK1  = 2'd2
   } out_src_t;

endpackage

// File: rtl/nvc_line_bank.sv
// One scanline bank: a read-then-clear port with registered data and a pixel write port.
// bank_en marks this bank as the write bank; clr_all opens the clear port regardless.
module nvc_line_bank
   import nvc_video_pkg::*;
#(
   parameter int             DW       = LB_DW,
   parameter int             LINE_LEN = LB_LINE_LEN,
   parameter int             XW       = LB_XW,
   parameter logic [DW-1:0]  TRANSP   = DW'(LB_TRANSP)
) (
   input  logic          clk,
   input  logic          bank_en,
   input  logic          clr_all,
   input  logic          rc_en,
   input  logic [XW-1:0] rc_addr,
   input  logic          wr_en,
   input  logic [XW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_r [LINE_LEN];
   logic [DW-1:0] rd_data_r;
   logic          rc_go_s;
   logic          wr_go_s;

   assign rc_go_s = rc_en && (clr_all || !bank_en);
   assign wr_go_s = wr_en && bank_en && !clr_all;
   assign rd_data = rd_data_r;

   // Read-before-clear on the read port; renderer writes on the write port.
   always_ff @(posedge clk) begin
      if (rc_go_s) begin
         rd_data_r       <= mem_r[rc_addr];
         mem_r[rc_addr]  <= TRANSP;
      end
      if (wr_go_s) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/nvc_line_buffer.sv
// Double-buffered sprite scanline buffer: renderer fills one bank while the other
// is streamed out and cleared behind the read pointer.
module nvc_line_buffer
   import nvc_video_pkg::*;
#(
   parameter int             DW       = LB_DW,
   parameter int             LINE_LEN = LB_LINE_LEN,
   parameter int             XW       = LB_XW,
   parameter logic [DW-1:0]  TRANSP   = DW'(LB_TRANSP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          line_swap,
   input  logic          wr_en,
   input  logic [XW-1:0] wr_x,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          busy
);

   localparam logic [XW-1:0] LEN_X  = XW'(LINE_LEN);
   localparam logic [XW-1:0] LAST_X = XW'(LINE_LEN - 1);

   lb_state_t     state_r;
   lb_state_t     state_nxt_s;
   logic          bank_sel_r;
   logic [XW-1:0] rd_x_r;
   logic [XW-1:0] clr_x_r;
   out_src_t      out_src_r;
   logic          dout_valid_r;

   logic          clearing_s;
   logic          rd_ok_s;
   logic          sat_s;
   logic          wr_ok_s;
   logic          swap_s;
   logic [XW-1:0] rc_addr_s;
   logic          rc_en_s;
   logic          wr_go_s;
   logic [DW-1:0] rd0_s;
   logic [DW-1:0] rd1_s;

   // Next-state and per-cycle access decode.
   always_comb begin
      state_nxt_s = state_r;
      clearing_s  = 1'b0;
      rd_ok_s     = 1'b0;
      sat_s       = 1'b0;
      wr_ok_s     = 1'b0;
      swap_s      = 1'b0;
      rc_addr_s   = rd_x_r;
      case (state_r)
         CLEAR: begin
            clearing_s = 1'b1;
            rc_addr_s  = clr_x_r;
            if (clr_x_r == LAST_X) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = CLEAR;
            end
         end
         RUN: begin
            swap_s  = line_swap;
            wr_ok_s = wr_en && (wr_data != TRANSP) && (wr_x < LEN_X);
            // A swap cycle suppresses the read so the new line starts cleanly at x=0.
            if (rd_en && !line_swap) begin
               if (rd_x_r < LEN_X) begin
                  rd_ok_s = 1'b1;
               end else begin
                  sat_s = 1'b1;
               end
            end else begin
               rd_ok_s = 1'b0;
               sat_s   = 1'b0;
            end
         end
         default: begin
            state_nxt_s = CLEAR;
         end
      endcase
   end

   assign rc_en_s = !reset && (clearing_s || rd_ok_s);
   assign wr_go_s = !reset && wr_ok_s;

   nvc_line_bank #(.DW(DW), .LINE_LEN(LINE_LEN), .XW(XW), .TRANSP(TRANSP)) u_bank0 (
      .clk     (clk),
      .bank_en (~bank_sel_r),
      .clr_all (clearing_s),
      .rc_en   (rc_en_s),
      .rc_addr (rc_addr_s),
      .wr_en   (wr_go_s),
      .wr_addr (wr_x),
      .wr_data (wr_data),
      .rd_data (rd0_s)
   );

   nvc_line_bank #(.DW(DW), .LINE_LEN(LINE_LEN), .XW(XW), .TRANSP(TRANSP)) u_bank1 (
      .clk     (clk),
      .bank_en (bank_sel_r),
      .clr_all (clearing_s),
      .rc_en   (rc_en_s),
      .rc_addr (rc_addr_s),
      .wr_en   (wr_go_s),
      .wr_addr (wr_x),
      .wr_data (wr_data),
      .rd_data (rd1_s)
   );

   // Control state: FSM, bank select, pointers and output source tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= CLEAR;
         bank_sel_r   <= 1'b0;
         rd_x_r       <= {XW{1'b0}};
         clr_x_r      <= {XW{1'b0}};
         out_src_r    <= SRC_TRANSP;
         dout_valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (clearing_s && (clr_x_r != LAST_X)) begin
            clr_x_r <= clr_x_r + XW'(1);
         end else begin
            clr_x_r <= {XW{1'b0}};
         end
         if (swap_s) begin
            bank_sel_r <= ~bank_sel_r;
            rd_x_r     <= {XW{1'b0}};
         end else if (rd_ok_s) begin
            rd_x_r <= rd_x_r + XW'(1);
         end
         dout_valid_r <= rd_ok_s || sat_s;
         // The bank register holds its last read, so dout only needs to remember its source.
         if (rd_ok_s) begin
            out_src_r <= bank_sel_r ? SRC_BANK0 : SRC_BANK1;
         end else if (sat_s) begin
            out_src_r <= SRC_TRANSP;
         end
      end
   end

   // Output mux over registered sources only.
   always_comb begin
      case (out_src_r)
         SRC_BANK0: dout = rd0_s;
         SRC_BANK1: dout = rd1_s;
         default:   dout = TRANSP;
      endcase
   end

   assign dout_valid = dout_valid_r;
   assign busy       = (state_r == CLEAR);

endmodule

// File: tb/tb_nvc_line_buffer.sv
// Directed bench for nvc_line_buffer: clear sweep, line readout, clear-behind,
// dropped writes, swap-cycle corner cases, saturation and mid-line reset.
module tb_nvc_line_buffer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       line_swap = 1'b0;
   logic       wr_en = 1'b0;
   logic [8:0] wr_x = 9'd0;
   logic [5:0] wr_data = 6'd0;
   logic       rd_en = 1'b0;
   logic [5:0] dout;
   logic       dout_valid;
   logic       busy;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [5:0] exp_pix [300];

   nvc_line_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .line_swap  (line_swap),
      .wr_en      (wr_en),
      .wr_x       (wr_x),
      .wr_data    (wr_data),
      .rd_en      (rd_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 300; i++) exp_pix[i] = 6'd0;
   endtask

   task automatic wr_pix(input logic [8:0] x, input logic [5:0] d);
      wr_en = 1'b1; wr_x = x; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic swap();
      line_swap = 1'b1;
      tick();
      line_swap = 1'b0;
   endtask

   // Hold rd_en for n cycles, checking each pixel one cycle after its request.
   task automatic read_line(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         tick();
         check($sformatf("%s_dout[%0d]", tag, i), dout, exp_pix[i]);
         check($sformatf("%s_vld[%0d]", tag, i), dout_valid, 1'b1);
      end
      rd_en = 1'b0;
      tick();
      check({tag, "_idle_vld"}, dout_valid, 1'b0);
      check({tag, "_idle_hold"}, dout, exp_pix[n-1]);
   endtask

   // Reset for one cycle then time the sweep; optionally poke a write at sweep cycle 100.
   task automatic do_reset(input bit poke, input string tag);
      int cnt;
      reset = 1'b1;
      tick();
      check({tag, "_busy0"}, busy, 1'b1);
      check({tag, "_dout0"}, dout, 6'd0);
      check({tag, "_vld0"}, dout_valid, 1'b0);
      reset = 1'b0;
      rd_en = 1'b0;
      cnt = 0;
      while (cnt < 400) begin
         if (poke && cnt == 100) begin
            wr_en = 1'b1; wr_x = 9'd10; wr_data = 6'h2A;
         end else begin
            wr_en = 1'b0;
         end
         tick();
         cnt++;
         if (!busy) break;
      end
      wr_en = 1'b0;
      check({tag, "_busy_len"}, cnt, 288);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_exp();
      tick();

      // Reset/clear; the write at sweep cycle 100 must be lost.
      do_reset(1'b1, "rst");
      swap();
      read_line(288, "sweep_wr");

      // Basic line into bank 1.
      wr_pix(9'd0, 6'h15);
      wr_pix(9'd5, 6'h2A);
      wr_pix(9'd287, 6'h3F);
      swap();
      clear_exp();
      exp_pix[0] = 6'h15; exp_pix[5] = 6'h2A; exp_pix[287] = 6'h3F;
      read_line(288, "basic");

      // Clear-behind: both banks read back empty.
      swap();
      swap();
      clear_exp();
      read_line(288, "clrbeh");

      // Drops and overwrite.
      wr_pix(9'd3, 6'h11);
      wr_pix(9'd3, 6'h00);
      wr_pix(9'd300, 6'h05);
      wr_pix(9'd7, 6'h22);
      wr_pix(9'd7, 6'h33);
      swap();
      clear_exp();
      exp_pix[3] = 6'h11; exp_pix[7] = 6'h33;
      read_line(288, "drops");

      // Write and read in the swap cycle.
      wr_pix(9'd0, 6'h1C);
      line_swap = 1'b1; rd_en = 1'b1;
      wr_en = 1'b1; wr_x = 9'd1; wr_data = 6'h09;
      tick();
      line_swap = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      check("swap_rd_vld", dout_valid, 1'b0);
      clear_exp();
      exp_pix[0] = 6'h1C; exp_pix[1] = 6'h09;
      read_line(288, "swapwr");

      // Saturation: reads past the line end return transparent with valid.
      wr_pix(9'd287, 6'h3F);
      swap();
      clear_exp();
      exp_pix[287] = 6'h3F;
      read_line(300, "sat");

      // Mid-line reset with pixels pending in both banks.
      wr_pix(9'd20, 6'h15);
      wr_pix(9'd200, 6'h2A);
      swap();
      wr_pix(9'd50, 6'h3F);
      clear_exp();
      exp_pix[20] = 6'h15;
      for (int i = 0; i < 150; i++) begin
         rd_en = 1'b1;
         tick();
         check($sformatf("mid_dout[%0d]", i), dout, exp_pix[i]);
      end
      do_reset(1'b0, "midrst");
      check("midrst_post_vld", dout_valid, 1'b0);
      swap();
      clear_exp();
      read_line(288, "post_b0");
      swap();
      read_line(288, "post_b1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
